// File: rtl/uop_sequencer_if.sv
// Handshake bundle between the cracker, the uop sequencer and the register-read/ALU stage.
// The slave modport is the sequencer's view; the master modport drives it.
interface uop_sequencer_if #(
    parameter int UOP_W    = 128,
    parameter int MAX_UOPS = 6,
    parameter int IDX_W    = 3
);
    logic                      in_valid;
    logic                      in_ready;
    logic [IDX_W-1:0]          in_count;
    logic [UOP_W*MAX_UOPS-1:0] in_uops;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [UOP_W-1:0]          out_uop;
    logic [IDX_W-1:0]          out_idx;
    logic                      out_first;
    logic                      out_last;
    logic                      err_bad_count;

    modport slave (
        input  in_valid, in_count, in_uops, flush, out_ready,
        output in_ready, out_valid, out_uop, out_idx, out_first, out_last, err_bad_count
    );
    modport master (
        output in_valid, in_count, in_uops, flush, out_ready,
        input  in_ready, out_valid, out_uop, out_idx, out_first, out_last, err_bad_count
    );
endinterface

// File: rtl/uop_sequencer.sv
// Holds one cracked bundle and issues its micro-ops in order, one per handshake.
// Optional counters are built when UOP_SEQ_STATS_EN is defined.
module uop_sequencer #(
    parameter int UOP_W    = 128,
    parameter int MAX_UOPS = 6,
    parameter int IDX_W    = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    uop_sequencer_if.slave bus
`ifdef UOP_SEQ_STATS_EN
    ,
    output logic [31:0]  stat_bundles,
    output logic [31:0]  stat_uops,
    output logic [31:0]  stat_stall_cycles,
    output logic [31:0]  stat_flushed_uops
`endif
);
    localparam logic [IDX_W-1:0] MAXC = IDX_W'(MAX_UOPS);

    logic             r_held;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_err;
    logic [UOP_W-1:0] r_buf [MAX_UOPS];

    logic w_issue, w_last, w_in_ready, w_acc, w_cnt_ok, w_cnt_bad;

    assign w_issue    = r_held & bus.out_ready;
    assign w_last     = r_held & (r_idx == r_cnt - 1'b1);
    // Ready may rise in the same cycle the final micro-op issues, so bundles run back-to-back.
    assign w_in_ready = reset_n & ~bus.flush & (~r_held | (w_issue & w_last));
    assign w_acc      = bus.in_valid & w_in_ready;
    assign w_cnt_ok   = (bus.in_count != '0) && (bus.in_count <= MAXC);
    assign w_cnt_bad  = bus.in_count > MAXC;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_held <= 1'b0;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_err  <= 1'b0;
            for (int k = 0; k < MAX_UOPS; k++) r_buf[k] <= '0;
        end else begin
            r_err <= w_acc & w_cnt_bad;
            if (bus.flush) begin
                r_held <= 1'b0;
                r_idx  <= '0;
            end else if (w_acc) begin
                if (w_cnt_ok) begin
                    // Slot 0 sits in the most significant UOP_W bits.
                    for (int k = 0; k < MAX_UOPS; k++)
                        r_buf[k] <= bus.in_uops[UOP_W*(MAX_UOPS-k)-1 -: UOP_W];
                    r_cnt  <= bus.in_count;
                    r_held <= 1'b1;
                end else begin
                    r_held <= 1'b0;
                end
                r_idx <= '0;
            end else if (w_issue) begin
                if (w_last) begin
                    r_held <= 1'b0;
                    r_idx  <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_held;
    assign bus.out_uop       = r_buf[r_idx];
    assign bus.out_idx       = r_idx;
    assign bus.out_first     = r_held & (r_idx == '0);
    assign bus.out_last      = w_last;
    assign bus.err_bad_count = r_err;

`ifdef UOP_SEQ_STATS_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    logic [31:0] w_flush_n;
    // Micro-op issuing alongside the flush was consumed downstream, so it is not discarded.
    assign w_flush_n = 32'(r_cnt - r_idx) - 32'(w_issue);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_bundles      <= '0;
            stat_uops         <= '0;
            stat_stall_cycles <= '0;
            stat_flushed_uops <= '0;
        end else begin
            if (w_acc)                      stat_bundles      <= sat_add(stat_bundles, 32'd1);
            if (w_issue)                    stat_uops         <= sat_add(stat_uops, 32'd1);
            if (r_held && !bus.out_ready)   stat_stall_cycles <= sat_add(stat_stall_cycles, 32'd1);
            if (bus.flush && r_held)        stat_flushed_uops <= sat_add(stat_flushed_uops, w_flush_n);
        end
    end
`endif
endmodule

// File: tb/tb_uop_sequencer.sv
// Randomized bench for uop_sequencer against a queue-based model of pending micro-ops.
module tb_uop_sequencer;
    localparam int UW = 128;
    localparam int MU = 6;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uop_sequencer_if #(.UOP_W(UW), .MAX_UOPS(MU), .IDX_W(IW)) bus ();

`ifdef UOP_SEQ_STATS_EN
    logic [31:0] stat_bundles, stat_uops, stat_stall_cycles, stat_flushed_uops;
`endif

    uop_sequencer #(.UOP_W(UW), .MAX_UOPS(MU), .IDX_W(IW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
`ifdef UOP_SEQ_STATS_EN
        ,
        .stat_bundles      (stat_bundles),
        .stat_uops         (stat_uops),
        .stat_stall_cycles (stat_stall_cycles),
        .stat_flushed_uops (stat_flushed_uops)
`endif
    );

    typedef struct {
        logic [UW-1:0] u;
        int            idx;
        int            cnt;
    } ent_t;

    ent_t          q[$];
    logic [UW-1:0] d_slot [MU];
    bit            m_err;
    int            n_tests = 0;
    int            n_fail  = 0;
    longint        m_bundles = 0, m_uops = 0, m_stalls = 0, m_flushed = 0;

    task automatic chk(input string tag, input logic [UW-1:0] got, input logic [UW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input int c, input bit rdy, input bit fl);
        bus.in_valid  = v;
        bus.in_count  = IW'(c);
        bus.out_ready = rdy;
        bus.flush     = fl;
        for (int k = 0; k < MU; k++) begin
            d_slot[k] = {$urandom, $urandom, $urandom, $urandom};
            bus.in_uops[UW*(MU-k)-1 -: UW] = d_slot[k];
        end
    endtask

    // Check at the falling edge, advance the model, then step past the rising edge.
    task automatic cyc();
        bit exp_rdy, issue, acc;
        int c;
        @(negedge clk);
        c = int'(bus.in_count);
        exp_rdy = !bus.flush && (q.size() == 0 || (bus.out_ready && q.size() == 1));
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("out_valid", bus.out_valid, q.size() != 0);
        chk("err_bad_count", bus.err_bad_count, m_err);
        if (q.size() != 0) begin
            chk("out_uop", bus.out_uop, q[0].u);
            chk("out_idx", bus.out_idx, q[0].idx);
            chk("out_first", bus.out_first, q[0].idx == 0);
            chk("out_last", bus.out_last, q[0].idx == q[0].cnt - 1);
        end
        issue = (q.size() != 0) && bus.out_ready;
        acc   = bus.in_valid && exp_rdy;
        m_err = acc && (c > MU);
        if (acc) m_bundles++;
        if (issue) m_uops++;
        if (q.size() != 0 && !bus.out_ready) m_stalls++;
        if (bus.flush) begin
            m_flushed += q.size() - (issue ? 1 : 0);
            q.delete();
        end else begin
            if (issue) void'(q.pop_front());
            if (acc && c >= 1 && c <= MU)
                for (int k = 0; k < c; k++) q.push_back('{u: d_slot[k], idx: k, cnt: c});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 1, 0);
            cyc();
        end
    endtask

    initial begin
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        drive(0, 0, 1, 0);
        #2;
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst out_uop", bus.out_uop, 0);
        chk("rst out_idx", bus.out_idx, 0);
        chk("rst out_first", bus.out_first, 0);
        chk("rst out_last", bus.out_last, 0);
        chk("rst err", bus.err_bad_count, 0);
        bus.in_valid = 1'b1;
        #1;
        chk("rst in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        drive(1, 2, 1, 0); cyc(); idle(3);

        drive(1, 4, 1, 0); cyc(); idle(3);
        drive(1, 1, 1, 0); cyc(); idle(2);

        drive(1, 6, 1, 0); cyc();
        for (int i = 0; i < 16; i++) begin drive(0, 0, pat[i%4], 0); cyc(); end

        drive(1, 5, 1, 0); cyc(); idle(2);
        drive(0, 0, 0, 1); cyc(); idle(2);

        drive(1, 0, 1, 0); cyc();
        drive(1, 3, 1, 0); cyc(); idle(4);
        drive(1, 7, 1, 0); cyc(); idle(3);

        // Asynchronous reset while idx 2 of a six-uop bundle is presented.
        drive(1, 6, 1, 0); cyc(); idle(2);
        chk("pre-reset idx", bus.out_idx, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async out_valid", bus.out_valid, 0);
        chk("async out_uop", bus.out_uop, 0);
        chk("async out_idx", bus.out_idx, 0);
        chk("async in_ready", bus.in_ready, 0);
        q.delete();
        m_err = 1'b0;
`ifdef UOP_SEQ_STATS_EN
        m_bundles = 0; m_uops = 0; m_stalls = 0; m_flushed = 0;
`endif
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(4);

        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 7), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0));
            cyc();
        end
        idle(8);

`ifdef UOP_SEQ_STATS_EN
        chk("stat_bundles", stat_bundles, m_bundles);
        chk("stat_uops", stat_uops, m_uops);
        chk("stat_stall_cycles", stat_stall_cycles, m_stalls);
        chk("stat_flushed_uops", stat_flushed_uops, m_flushed);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uop_sequencer.md
Name: uop_sequencer

Overview:
- Sits directly downstream of the instruction-cracking function in decode.
- Accepts one cracked instruction per handshake: a micro-op count (0..6) and six packed alu_inp_t slots.
- Holds the bundle and issues its micro-ops in order, one per cycle, to the register-read/ALU stage over a valid/ready handshake.
- Tags each issued micro-op with first/last markers and its slot index. Supports a pipeline flush from branch resolution.

Parameters:
- UOP_W, 128: width in bits of one alu_inp_t; must equal $bits(alu_inp_t).
- MAX_UOPS, 6: slots per bundle; fixed by the cracker output format.
- IDX_W, 3: width of slot index and count fields; ceil(log2(MAX_UOPS+1)).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  cracked bundle present.
- in_ready  out  1  sequencer accepts the bundle this cycle.
- in_count  in  IDX_W  number of valid micro-ops, 0..MAX_UOPS.
- in_uops  in  UOP_W*MAX_UOPS  packed slots; slot 0 occupies the MSBs (bits [0:UOP_W-1] in big-endian numbering).
- flush  in  1  synchronous kill of held bundle; highest priority.
- out_valid  out  1  micro-op presented.
- out_ready  in  1  downstream consumes the micro-op.
- out_uop  out  UOP_W  current micro-op.
- out_idx  out  IDX_W  slot index of out_uop.
- out_first  out  1  out_idx == 0.
- out_last  out  1  out_idx == held count − 1.
- err_bad_count  out  1  one-cycle pulse: an accepted bundle had in_count > MAX_UOPS.

Behaviour:
- State: `held` (bundle valid), `buf[0:MAX_UOPS-1]`, `cnt`, `idx`.
  - IDLE: held = 0.
  - ISSUE: held = 1, idx < cnt.
- Reset (reset_n low, asynchronous): held = 0, idx = 0, cnt = 0, buf cleared.
  - out_valid = 0, out_uop = 0, out_idx = 0, out_first = 0, out_last = 0, err_bad_count = 0.
  - in_ready = 0 while reset_n is low.
  - Reset asserted mid-bundle discards the bundle; no partial issue resumes after reset.
- Outputs:
  - out_valid = held.
  - out_uop = buf[idx], out_idx = idx, driven from registers (no combinational path from in_* to out_*).
- in_ready = !flush && (!held || (out_valid && out_ready && out_last)).
  - A new bundle may be accepted in the same cycle the last micro-op of the previous bundle issues (back-to-back, no bubble).
- Accept (in_valid && in_ready):
  - in_count in 1..MAX_UOPS: load buf, cnt = in_count, idx = 0, held = 1. First micro-op is valid the following cycle (latency 1).
  - in_count == 0 (nop): consumed with no issue; held is cleared if it was finishing, otherwise unchanged; in_ready stays high next cycle.
  - in_count > MAX_UOPS: bundle dropped, err_bad_count pulses next cycle, held = 0.
- Issue (out_valid && out_ready):
  - If !out_last: idx increments.
  - If out_last: held = 0, idx = 0, unless an accept occurs the same cycle, in which case the accept rule applies.
- Stall: while out_valid && !out_ready, out_uop, out_idx, out_first and out_last stay stable.
- Flush:
  - Next edge: held = 0, idx = 0.
  - Any same-cycle issue is still counted as consumed downstream, but no new bundle is accepted (in_ready = 0).
  - Flush in IDLE has no effect.
- out_first and out_last may both be 1 (count == 1).

Optional Feature:
- Macro: UOP_SEQ_STATS_EN.
- With the macro, the block adds the following, all cleared by reset_n and saturating at all-ones:
  - Output stat_bundles (32 bits): counts accepted bundles, including count-0 bundles.
  - Output stat_uops (32 bits): counts issued micro-ops.
  - Output stat_stall_cycles (32 bits): counts cycles with out_valid && !out_ready.
  - Output stat_flushed_uops (32 bits): counts remaining unissued micro-ops (cnt − idx, minus one if that micro-op issues the same cycle) discarded by flush.
- Without the macro, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then a count=2 bundle (add reg,reg) with out_ready=1 -> out_valid high in cycles 1-2 with idx 0,1; first=1 at idx 0, last=1 at idx 1; idle in cycle 3.
- Back-to-back count=4 then count=1 bundles, out_ready=1 -> 5 consecutive issue cycles, no bubble; in_ready high in the cycle idx=3 issues.
- count=6 bundle with out_ready toggling 1,0,0,1,... -> out_uop stable during stalls; all 6 slots issued in order with no duplicates.
- count=5 bundle, flush asserted after idx 1 issues -> no further out_valid; stat_flushed_uops = 3 with UOP_SEQ_STATS_EN.
- count=0 bundle followed by count=3 -> nop issues nothing; count=3 bundle issues starting the cycle after its accept. count=7 bundle -> err_bad_count pulses once, nothing issued.
- reset_n dropped asynchronously mid count=6 bundle at idx 2 -> outputs zero immediately; after release in_ready=1 and no stale micro-ops issue.
